// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch-side next-PC selection and branch-prediction recovery. Predictor
//   outputs for the current fetch PC are turned into an effective prediction.
//   Hits are recorded in a small in-order queue. When Execute resolves a
//   branch, the queue head is compared against the actual outcome, and fetch
//   is redirected to the correct path on a mismatch.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   stall_i                 freezes PC, queue and counter
//   branch_hit_i            predictor hit for pc_o
//   branch_decision_i       predictor taken decision for pc_o
//   branch_target_addr_i    predicted target for pc_o
//   exe_is_branch_i         a branch is resolving in Execute
//   exe_pc_i                PC of the resolving branch
//   exe_taken_i             actual outcome
//   exe_target_addr_i       actual taken target
//   pc_o                    current fetch PC (registered)
//   branch_misprediction_o  resolving branch was mispredicted (combinational)
//   redirect_addr_o         correct next PC for the resolving branch
//   queue_full_o            prediction queue holds DEPTH entries
//   mispredict_cnt_o        mispredictions since reset (wraps)
module pc_redirect_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_hit_i,
  input  logic            branch_decision_i,
  input  logic [XLEN-1:0] branch_target_addr_i,
  input  logic            exe_is_branch_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            exe_taken_i,
  input  logic [XLEN-1:0] exe_target_addr_i,
  output logic [XLEN-1:0] pc_o,
  output logic            branch_misprediction_o,
  output logic [XLEN-1:0] redirect_addr_o,
  output logic            queue_full_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam int unsigned     CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  // Queue storage: data needs no reset, validity is carried by count.
  logic [XLEN-1:0] q_pc     [DEPTH];
  logic            q_taken  [DEPTH];
  logic [XLEN-1:0] q_target [DEPTH];

  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cnt_q;

  logic            queue_full;
  logic            pred_taken;
  logic            head_match;
  logic            p_taken;
  logic [XLEN-1:0] p_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_addr;
  logic            push, pop, flush;

  assign queue_full = (count == FULL_CNT);

  // A full queue cannot record the prediction, so a taken hit is demoted to
  // not-taken: Execute will see no matching entry and recover if needed.
  assign pred_taken = branch_hit_i & branch_decision_i & ~queue_full;

  assign head_match = (count != '0) && (q_pc[rd_ptr] == exe_pc_i);
  assign p_taken    = head_match ? q_taken[rd_ptr]  : 1'b0;
  assign p_target   = head_match ? q_target[rd_ptr] : '0;

  assign mispredict = ~rst_i & exe_is_branch_i &
                      ((exe_taken_i != p_taken) |
                       (exe_taken_i & (p_target != exe_target_addr_i)));

  assign redirect_addr = exe_taken_i ? exe_target_addr_i : exe_pc_i + XLEN'(4);

  // Flush dominates: anything fetched this cycle is on the wrong path.
  assign flush = ~stall_i & mispredict;
  assign push  = ~stall_i & branch_hit_i & ~queue_full & ~mispredict;
  assign pop   = ~stall_i & exe_is_branch_i & head_match & ~mispredict;

  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count + CW'(1);
        2'b01:   count_d = count - CW'(1);
        default: count_d = count;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (stall_i) begin
      pc_d = pc_q;
    end else if (mispredict) begin
      pc_d = redirect_addr;
    end else if (pred_taken) begin
      pc_d = branch_target_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= PC_RESET;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      count <= count_d;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt_q  <= cnt_q + 32'd1;
      end else begin
        // DEPTH is a power of two, so pointer overflow is the wrap.
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      q_pc[wr_ptr]     <= pc_q;
      q_taken[wr_ptr]  <= pred_taken;
      q_target[wr_ptr] <= branch_target_addr_i;
    end
  end

  assign pc_o                   = pc_q;
  assign branch_misprediction_o = mispredict;
  assign redirect_addr_o        = redirect_addr;
  assign queue_full_o           = queue_full;
  assign mispredict_cnt_o       = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0;

  // Clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i, stall_i;
  logic            branch_hit_i, branch_decision_i;
  logic [XLEN-1:0] branch_target_addr_i;
  logic            exe_is_branch_i, exe_taken_i;
  logic [XLEN-1:0] exe_pc_i, exe_target_addr_i;
  logic [XLEN-1:0] pc_o, redirect_addr_o;
  logic            branch_misprediction_o, queue_full_o;
  logic [31:0]     mispredict_cnt_o;

  pc_redirect_unit #(.XLEN(XLEN), .PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .stall_i                (stall_i),
    .branch_hit_i           (branch_hit_i),
    .branch_decision_i      (branch_decision_i),
    .branch_target_addr_i   (branch_target_addr_i),
    .exe_is_branch_i        (exe_is_branch_i),
    .exe_pc_i               (exe_pc_i),
    .exe_taken_i            (exe_taken_i),
    .exe_target_addr_i      (exe_target_addr_i),
    .pc_o                   (pc_o),
    .branch_misprediction_o (branch_misprediction_o),
    .redirect_addr_o        (redirect_addr_o),
    .queue_full_o           (queue_full_o),
    .mispredict_cnt_o       (mispredict_cnt_o)
  );

  // Reference model: in-flight predictions as a plain FIFO of records.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t      model_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_i = 1'b0; stall_i = 1'b0;
    branch_hit_i = 1'b0; branch_decision_i = 1'b0; branch_target_addr_i = '0;
    exe_is_branch_i = 1'b0; exe_pc_i = '0; exe_taken_i = 1'b0; exe_target_addr_i = '0;
  endtask

  task automatic model_reset();
    model_q.delete();
    m_pc  = PC_RESET;
    m_cnt = 32'd0;
  endtask

  // Driver + scoreboard for one cycle: inputs are already applied by the caller.
  task automatic cycle();
    logic        full, pt, match, p_t, mis;
    logic [31:0] p_tg, redir;
    #1;
    full  = (model_q.size() == DEPTH);
    pt    = branch_hit_i & branch_decision_i & ~full;
    match = 1'b0; p_t = 1'b0; p_tg = 32'd0;
    if (model_q.size() != 0) begin
      if (model_q[0].pc == exe_pc_i) begin
        match = 1'b1;
        p_t   = model_q[0].taken;
        p_tg  = model_q[0].target;
      end
    end
    mis   = !rst_i && exe_is_branch_i &&
            ((exe_taken_i != p_t) || (exe_taken_i && (p_tg != exe_target_addr_i)));
    redir = exe_taken_i ? exe_target_addr_i : exe_pc_i + 32'd4;

    chk("pc", pc_o, m_pc);
    chk("full", 32'(queue_full_o), 32'(full));
    chk("cnt", mispredict_cnt_o, m_cnt);
    chk("mispred", 32'(branch_misprediction_o), 32'(mis));
    chk("redirect", redirect_addr_o, redir);

    @(posedge clk_i); #1;

    if (rst_i) begin
      model_reset();
    end else if (!stall_i) begin
      if (mis) begin
        model_q.delete();
        m_pc = redir;
        m_cnt++;
      end else begin
        if (exe_is_branch_i && match) void'(model_q.pop_front());
        if (branch_hit_i && !full)
          model_q.push_back('{pc: m_pc, taken: pt, target: branch_target_addr_i});
        m_pc = pt ? branch_target_addr_i : m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    model_reset();
    rst_i = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset state and sequential fetch
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_full", 32'(queue_full_o), 32'd0);
    chk("rst_cnt", mispredict_cnt_o, 32'd0);
    chk("rst_mis", 32'(branch_misprediction_o), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("seq_pc", pc_o, 32'hC);

    // Correctly predicted taken branch
    cycle();
    chk("pc_10", pc_o, 32'h10);
    branch_hit_i = 1; branch_decision_i = 1; branch_target_addr_i = 32'h100;
    cycle();
    chk("pred_taken_pc", pc_o, 32'h100);
    idle();
    exe_is_branch_i = 1; exe_pc_i = 32'h10; exe_taken_i = 1; exe_target_addr_i = 32'h100;
    cycle();
    chk("good_pred_cnt", mispredict_cnt_o, 32'd0);
    chk("good_pred_pc", pc_o, 32'h104);

    // Predicted taken, resolves not-taken
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    branch_hit_i = 1; branch_decision_i = 1; branch_target_addr_i = 32'h100;
    cycle();
    idle();
    exe_is_branch_i = 1; exe_pc_i = 32'h10; exe_taken_i = 0;
    #1;
    chk("nt_mis", 32'(branch_misprediction_o), 32'd1);
    chk("nt_redirect", redirect_addr_o, 32'h14);
    cycle();
    chk("nt_pc", pc_o, 32'h14);
    chk("nt_cnt", mispredict_cnt_o, 32'd1);

    // Fill the queue, then a fifth hit is demoted to not-taken
    idle();
    branch_hit_i = 1; branch_decision_i = 1;
    for (int i = 0; i < 4; i++) begin
      branch_target_addr_i = 32'h300 + 32'(i) * 32'h100;
      cycle();
    end
    chk("full_set", 32'(queue_full_o), 32'd1);
    branch_target_addr_i = 32'h700;
    cycle();
    chk("full_demote_pc", pc_o, 32'h604);
    idle();
    exe_is_branch_i = 1; exe_pc_i = 32'h600; exe_taken_i = 1; exe_target_addr_i = 32'h800;
    cycle();
    chk("full_recover_pc", pc_o, 32'h800);
    chk("full_cleared", 32'(queue_full_o), 32'd0);

    // Misprediction with a same-cycle hit: the push is dropped
    idle();
    branch_hit_i = 1; branch_decision_i = 1; branch_target_addr_i = 32'h900;
    cycle();
    branch_target_addr_i = 32'hA00;
    exe_is_branch_i = 1; exe_pc_i = 32'h50; exe_taken_i = 1; exe_target_addr_i = 32'hB00;
    cycle();
    chk("flush_pc", pc_o, 32'hB00);
    idle();
    exe_is_branch_i = 1; exe_pc_i = 32'h900; exe_taken_i = 1; exe_target_addr_i = 32'hA00;
    #1;
    chk("dropped_push", 32'(branch_misprediction_o), 32'd1);
    cycle();

    // Stall while a misprediction is pending
    idle();
    stall_i = 1;
    exe_is_branch_i = 1; exe_pc_i = 32'h40; exe_taken_i = 1; exe_target_addr_i = 32'hC00;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_pc", pc_o, 32'hA00);
    chk("stall_cnt", mispredict_cnt_o, 32'd4);
    stall_i = 0;
    cycle();
    idle();
    cycle();
    chk("unstall_cnt", mispredict_cnt_o, 32'd5);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_i                = ($urandom_range(0, 59) == 0);
      stall_i              = ($urandom_range(0, 7) == 0);
      branch_hit_i         = ($urandom_range(0, 2) != 0);
      branch_decision_i    = 1'($urandom_range(0, 1));
      branch_target_addr_i = 32'($urandom_range(1, 15)) << 8;
      exe_is_branch_i      = 1'($urandom_range(0, 1));
      exe_taken_i          = 1'($urandom_range(0, 1));
      exe_pc_i             = 32'($urandom_range(0, 255)) << 2;
      exe_target_addr_i    = 32'($urandom_range(1, 15)) << 8;
      if (model_q.size() != 0 && $urandom_range(0, 3) != 0) begin
        exe_pc_i = model_q[0].pc;
        if ($urandom_range(0, 3) != 0) begin
          exe_taken_i       = model_q[0].taken;
          exe_target_addr_i = model_q[0].target;
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Fetch-side program-counter and prediction-recovery unit. It sits directly downstream of the branch predictor and consumes its hit, decision and target outputs to select the next fetch PC. Predictions for branches still in flight are held in a small in-order queue. When a branch resolves in Execute, the unit compares the outcome against the queued prediction, raises a misprediction flag and redirects fetch to the correct path.

## Interface
Parameters:
- XLEN, 32, address width
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- DEPTH, 4, prediction-queue entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; the only clock
- rst_i  in  1  reset, synchronous, active-high
- stall_i  in  1  pipeline stall; freezes PC, queue and counter
- branch_hit_i  in  1  predictor hit for current pc_o
- branch_decision_i  in  1  predictor taken decision for current pc_o
- branch_target_addr_i  in  XLEN  predicted target for current pc_o
- exe_is_branch_i  in  1  a branch/jal is resolving in Execute this cycle
- exe_pc_i  in  XLEN  PC of the resolving branch
- exe_taken_i  in  1  actual outcome
- exe_target_addr_i  in  XLEN  actual taken target
- pc_o  out  XLEN  current fetch PC (registered)
- branch_misprediction_o  out  1  resolving branch was mispredicted (combinational)
- redirect_addr_o  out  XLEN  correct next PC when mispredicted
- queue_full_o  out  1  prediction queue full (registered)
- mispredict_cnt_o  out  32  count of mispredictions since reset

## Operation
- Queue entry fields: {pc, taken, target}. Circular buffer with rd_ptr, wr_ptr and a count of log2(DEPTH)+1 bits.
- Effective fetch prediction:
  - pred_taken = branch_hit_i & branch_decision_i & ~queue_full.
  - When queue_full is set, a hit is treated as not-taken and is not queued.
- Push: occurs when ~stall_i & branch_hit_i & ~queue_full & ~branch_misprediction_o. The entry is {pc_o, pred_taken, branch_target_addr_i}.
- Resolve: evaluated when exe_is_branch_i.
  - head_match = (count≠0) & (head.pc == exe_pc_i).
  - On head_match, the head entry supplies the predicted taken/target, and the entry is popped if ~stall_i.
  - Otherwise the prediction is not-taken and nothing is popped.
- Misprediction (combinational):
  - branch_misprediction_o = exe_is_branch_i & ((exe_taken_i ≠ p_taken) | (exe_taken_i & p_target ≠ exe_target_addr_i)).
  - It is forced to 0 during rst_i.
- redirect_addr_o = exe_taken_i ? exe_target_addr_i : exe_pc_i + 4, with modulo-2^XLEN wrap.
- Flush: on ~stall_i & branch_misprediction_o, the queue empties (count, rd_ptr and wr_ptr → 0). Flush overrides a same-cycle push and pop.
- Simultaneous push and pop without misprediction: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- Next-PC priority, registered at the clock edge:
  1. rst_i → PC_RESET
  2. stall_i → hold
  3. branch_misprediction_o → redirect_addr_o
  4. pred_taken → branch_target_addr_i
  5. otherwise → pc_o + 4
- mispredict_cnt_o increments by 1 on each ~stall_i & branch_misprediction_o cycle. It wraps at 2^32.

## Timing
- Reset values (after one rst_i edge):
  - pc_o = PC_RESET
  - queue empty
  - queue_full_o = 0
  - mispredict_cnt_o = 0
  - branch_misprediction_o = 0
- pc_o changes one cycle after the predictor inputs it depends on; there is no bubble on a predicted-taken hit.
- Misprediction to redirect: branch_misprediction_o is asserted in the resolve cycle, and pc_o = redirect_addr_o on the next edge.
- The queue pops in the resolve cycle, so a queued entry is visible to Execute one cycle after it is pushed at the earliest.
- stall_i freezes every register, including pointers and the counter. Combinational outputs still reflect the current inputs.
- rst_i asserted mid-operation takes effect at the next edge regardless of stall_i or a pending redirect. All in-flight entries are discarded.
- queue_full_o is set when count == DEPTH. It drops in the cycle after a pop or flush.

## Test plan
- Reset, then no hits for 3 cycles → pc_o sequence 0x0, 0x4, 0x8, 0xC; queue empty; counter 0.
- Hit at pc 0x10 with decision 1 and target 0x100; resolve exe_pc=0x10, taken, target 0x100 → next pc_o = 0x100, no misprediction, entry popped, counter stays 0.
- Same branch predicted taken to 0x100 but resolves not-taken → branch_misprediction_o = 1, redirect_addr_o = 0x14, pc_o = 0x14 next cycle, queue flushed, counter = 1.
- Push 4 taken hits with no resolves (DEPTH=4) → queue_full_o = 1. A 5th hit with decision 1 fetches pc+4 and is not queued. Resolving that 5th branch as taken → misprediction to its exe target.
- Misprediction and a new hit in the same cycle → queue count = 0 afterwards (push dropped); pc_o = redirect_addr_o.
- stall_i held 3 cycles during a pending misprediction → pc_o, queue and counter unchanged. On the first unstalled cycle, the redirect and count increment take effect once.
